// File: rtl/gain_switch_controller.sv
// Gain-switch controller: chooses c1 (high gain) or c2 (low gain) with fast attack / slow release.
// Optional macro GAIN_SWITCH_STATS_EN adds a saturating 16-bit switch_count output.
module gain_switch_controller #(
  parameter int TH_HIGH      = 960,
  parameter int TH_LOW       = 480,
  parameter int HOLD_SAMPLES = 64,
  parameter int XFADE_LEN    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_3M,
  input  logic [10:0] data_c1,
  input  logic        force_en,
  input  logic        force_sel,
  output logic        select,
  output logic        busy,
  output logic [1:0]  state
`ifdef GAIN_SWITCH_STATS_EN
  , output logic [15:0] switch_count
`endif
);

  // Handshake: none; every input is sampled only on clk edges where enable_3M=1.
  typedef enum logic [1:0] {
    HG    = 2'b00,
    XF_LG = 2'b01,
    LG    = 2'b10,
    XF_HG = 2'b11
  } state_t;

  localparam int XW = (XFADE_LEN > 1) ? $clog2(XFADE_LEN) : 1;
  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  localparam logic [XW-1:0] XF_LOAD = XW'(XFADE_LEN - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_SAMPLES);
  localparam logic [10:0] TH_HIGH_U = 11'(TH_HIGH);
  localparam logic [10:0] TH_LOW_U  = 11'(TH_LOW);

  state_t        cur_state, nxt_state;
  logic [XW-1:0] xf_cnt, nxt_xf_cnt;
  logic [HW-1:0] hold_cnt, nxt_hold_cnt, hold_inc;
  logic [10:0]   mag;
  logic          attack, quiet, load_xf;

  // -1024 negates to 0x400, which read as unsigned is exactly 1024.
  assign mag    = data_c1[10] ? (~data_c1 + 11'd1) : data_c1;
  assign attack = (mag >= TH_HIGH_U);
  assign quiet  = (mag < TH_LOW_U);
  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= HG;
      xf_cnt    <= '0;
      hold_cnt  <= '0;
    end else if (enable_3M) begin
      cur_state <= nxt_state;
      xf_cnt    <= nxt_xf_cnt;
      hold_cnt  <= nxt_hold_cnt;
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    nxt_xf_cnt   = xf_cnt;
    nxt_hold_cnt = hold_cnt;
    load_xf      = 1'b0;
    if (force_en) begin
      nxt_hold_cnt = '0;
      if (force_sel != select) begin
        nxt_state = force_sel ? XF_LG : XF_HG;
        load_xf   = 1'b1;
      end else if (cur_state == XF_LG || cur_state == XF_HG) begin
        // Already fading toward the forced side: let the fade finish.
        if (xf_cnt == '0) nxt_state = (cur_state == XF_LG) ? LG : HG;
        else              nxt_xf_cnt = xf_cnt - XW'(1);
      end
    end else begin
      unique case (cur_state)
        HG: if (attack) begin
          nxt_state = XF_LG;
          load_xf   = 1'b1;
        end
        XF_LG: begin
          if (xf_cnt == '0) begin
            nxt_state    = LG;
            nxt_hold_cnt = '0;
          end else begin
            nxt_xf_cnt = xf_cnt - XW'(1);
          end
        end
        LG: begin
          nxt_hold_cnt = quiet ? hold_inc : '0;
          if (quiet && hold_inc == HOLD_MAX) begin
            nxt_state = XF_HG;
            load_xf   = 1'b1;
          end
        end
        XF_HG: begin
          if (attack) begin
            nxt_state = XF_LG;
            load_xf   = 1'b1;
          end else if (xf_cnt == '0) begin
            nxt_state = HG;
          end else begin
            nxt_xf_cnt = xf_cnt - XW'(1);
          end
        end
        default: nxt_state = HG;
      endcase
    end
    if (load_xf) nxt_xf_cnt = XF_LOAD;
  end

  // Outputs decode the registered state, so they change only on the strobe edge.
  assign state  = cur_state;
  assign select = cur_state[1] ^ cur_state[0];
  assign busy   = cur_state[0];

`ifdef GAIN_SWITCH_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      switch_count <= '0;
    else if (enable_3M && load_xf && switch_count != 16'hFFFF)
      switch_count <= switch_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_gain_switch_controller.sv
// Directed bench for gain_switch_controller; stats checks run when GAIN_SWITCH_STATS_EN is defined.
module tb_gain_switch_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable_3M = 1'b0;
  logic [10:0] data_c1 = '0;
  logic        force_en = 1'b0;
  logic        force_sel = 1'b0;
  logic        select, busy;
  logic [1:0]  state;
`ifdef GAIN_SWITCH_STATS_EN
  logic [15:0] switch_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  gain_switch_controller dut (
    .clk(clk), .reset(reset), .enable_3M(enable_3M), .data_c1(data_c1),
    .force_en(force_en), .force_sel(force_sel),
    .select(select), .busy(busy), .state(state)
`ifdef GAIN_SWITCH_STATS_EN
    , .switch_count(switch_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; enable_3M = 1'b0; force_en = 1'b0; force_sel = 1'b0; data_c1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // n strobes of sample d; outputs are read on the negedge after the last one.
  task automatic strobes(input int n, input logic [10:0] d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_c1 = d; enable_3M = 1'b1;
      @(negedge clk);
      enable_3M = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (state !== 2'b00 || select !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: state=%b select=%b busy=%b, expected 00/0/0", state, select, busy);
    end
  endtask

  task automatic test_attack();
    do_reset();
    strobes(1, 11'd970);
    tests_run++;
    if (state !== 2'b01 || select !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL attack_enter: state=%b select=%b busy=%b, expected 01/1/1", state, select, busy);
    end
    strobes(15, 11'd0);
    tests_run++;
    if (state !== 2'b01 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL attack_15: state=%b busy=%b, expected 01/1", state, busy);
    end
    strobes(1, 11'd0);
    tests_run++;
    if (state !== 2'b10 || busy !== 1'b0 || select !== 1'b1) begin
      tests_failed++;
      $display("FAIL attack_16: state=%b busy=%b select=%b, expected 10/0/1", state, busy, select);
    end
  endtask

  task automatic test_neg_full_scale();
    do_reset();
    strobes(1, 11'h441);  // -959
    tests_run++;
    if (state !== 2'b00) begin
      tests_failed++;
      $display("FAIL neg_959: state=%b, expected 00", state);
    end
    strobes(1, 11'h400);  // -1024
    tests_run++;
    if (state !== 2'b01 || select !== 1'b1) begin
      tests_failed++;
      $display("FAIL neg_1024: state=%b select=%b, expected 01/1", state, select);
    end
  endtask

  task automatic test_release();
    do_reset();
    strobes(1, 11'd1000);
    strobes(16, 11'd0);
    strobes(63, 11'd100);
    strobes(1, 11'd500);
    strobes(63, 11'd100);
    tests_run++;
    if (state !== 2'b10 || select !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_63: state=%b select=%b, expected 10/1", state, select);
    end
    strobes(1, 11'd100);
    tests_run++;
    if (state !== 2'b11 || select !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_64: state=%b select=%b busy=%b, expected 11/0/1", state, select, busy);
    end
    strobes(15, 11'd100);
    tests_run++;
    if (state !== 2'b11) begin
      tests_failed++;
      $display("FAIL release_xf15: state=%b, expected 11", state);
    end
    strobes(1, 11'd100);
    tests_run++;
    if (state !== 2'b00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_hg: state=%b busy=%b, expected 00/0", state, busy);
    end
  endtask

  task automatic test_abort();
    do_reset();
    strobes(1, 11'd1000);
    strobes(16, 11'd0);
    strobes(64, 11'd0);
    strobes(5, 11'd0);
    tests_run++;
    if (state !== 2'b11) begin
      tests_failed++;
      $display("FAIL abort_pre: state=%b, expected 11", state);
    end
    strobes(1, 11'd1000);
    tests_run++;
    if (state !== 2'b01 || select !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_enter: state=%b select=%b, expected 01/1", state, select);
    end
    strobes(15, 11'd0);
    tests_run++;
    if (state !== 2'b01) begin
      tests_failed++;
      $display("FAIL abort_15: state=%b, expected 01", state);
    end
    strobes(1, 11'd0);
    tests_run++;
    if (state !== 2'b10) begin
      tests_failed++;
      $display("FAIL abort_16: state=%b, expected 10", state);
    end
  endtask

  task automatic test_force_gating();
    do_reset();
    force_en = 1'b1; force_sel = 1'b1;
    strobes(1, 11'd0);
    tests_run++;
    if (state !== 2'b01) begin
      tests_failed++;
      $display("FAIL force_xf: state=%b, expected 01", state);
    end
    strobes(16, 11'd0);
    strobes(100, 11'd0);
    tests_run++;
    if (state !== 2'b10 || select !== 1'b1) begin
      tests_failed++;
      $display("FAIL force_hold: state=%b select=%b, expected 10/1", state, select);
    end
    force_sel = 1'b0;
    strobes(1, 11'd1000);
    tests_run++;
    if (state !== 2'b11 || select !== 1'b0) begin
      tests_failed++;
      $display("FAIL force_back: state=%b select=%b, expected 11/0", state, select);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      data_c1 = (i % 2 == 0) ? 11'd1023 : 11'h400;
    end
    @(negedge clk);
    tests_run++;
    if (state !== 2'b00 || select !== 1'b0) begin
      tests_failed++;
      $display("FAIL gating: state=%b select=%b, expected 00/0", state, select);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    strobes(1, 11'd1000);
    strobes(3, 11'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (state !== 2'b00 || select !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: state=%b select=%b busy=%b, expected 00/0/0", state, select, busy);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef GAIN_SWITCH_STATS_EN
  task automatic test_stats();
    do_reset();
    strobes(1, 11'd1000);
    strobes(16, 11'd0);
    force_en = 1'b1; force_sel = 1'b0;
    strobes(1, 11'd0);
    force_en = 1'b0;
    strobes(2, 11'd0);
    strobes(1, 11'd1000);
    tests_run++;
    if (switch_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL stats_count: switch_count=%0d, expected 3", switch_count);
    end
    do_reset();
    tests_run++;
    if (switch_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL stats_reset: switch_count=%0d, expected 0", switch_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_attack();
    test_neg_full_scale();
    test_release();
    test_abort();
    test_force_gating();
    test_reset_mid();
`ifdef GAIN_SWITCH_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
